// File: rtl/alu_pkg.sv
// Shared ALU control encodings and legality check, used by the arbiter and the ALU decoder.
package alu_pkg;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1010;

  function automatic logic is_legal_alu_op(input logic [ALU_CTRL_W-1:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SLT,
      ALU_SLTU, ALU_SUB, ALU_XOR, ALU_SRL, ALU_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer; a load may coincide with a drain of the previous entry.
module alu_rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             illegal,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             err
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      y     <= '0;
      zero  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      // illegal ops never see the ALU; report a clean zero result instead
      valid <= 1'b1;
      y     <= illegal ? '0 : alu_y;
      zero  <= illegal | alu_zero;
      err   <= illegal;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_y,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_y,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_y,
  input  logic              alu_zero
);
  localparam int NP = 2;

  logic [NP-1:0]              req_valid, rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [NP-1:0]              slot_free, elig, grant;
  logic [NP-1:0][CTRL_W-1:0]  req_ctrl;
  logic [NP-1:0][WIDTH-1:0]   req_a, req_b, rsp_y;
  logic                       last_grant, gsel, legal;
  logic [CTRL_W-1:0]          sel_ctrl;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_ctrl  = {req1_ctrl, req0_ctrl};
  assign req_a     = {req1_a, req0_a};
  assign req_b     = {req1_b, req0_b};

  assign slot_free = ~rsp_valid | rsp_ready;
  assign elig      = req_valid & slot_free;

  always_comb begin
    grant = '0;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  assign gsel     = grant[1];
  assign sel_ctrl = req_ctrl[gsel];
  assign legal    = is_legal_alu_op(sel_ctrl);

  // Idle or illegal cycles present all-zero inputs so nothing undefined reaches the ALU.
  always_comb begin
    alu_ctrl = '0;
    alu_a    = '0;
    alu_b    = '0;
    if ((|grant) && legal) begin
      alu_ctrl = sel_ctrl;
      alu_a    = req_a[gsel];
      alu_b    = req_b[gsel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (|grant) last_grant <= gsel;
  end

  for (genvar i = 0; i < NP; i++) begin : g_slot
    alu_rsp_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (grant[i]),
      .illegal  (!legal),
      .alu_y    (alu_y),
      .alu_zero (alu_zero),
      .ready    (rsp_ready[i]),
      .valid    (rsp_valid[i]),
      .y        (rsp_y[i]),
      .zero     (rsp_zero[i]),
      .err      (rsp_err[i])
    );
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_y     = rsp_y[0];
  assign rsp1_y     = rsp_y[1];
  assign rsp0_zero  = rsp_zero[0];
  assign rsp1_zero  = rsp_zero[1];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_err   = rsp_err[1];
endmodule
